// File: rtl/boot_load_seq_pkg.sv
// Shared types and default sizing for the boot sequencer.
package boot_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_HOLD,
    ST_RUN,
    ST_FAULT
  } boot_state_t;

  localparam int DEF_DATA_W       = 32;
  localparam int DEF_ADDR_W       = 10;
  localparam int DEF_RESET_CYCLES = 2;
  localparam int DEF_WD_LIMIT     = 1024;

  // Width of a down-counter able to hold the larger of two preload values.
  function automatic int cnt_width(input int a, input int b);
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/boot_load_seq_if.sv
// Image load stream plus RAM write port of the boot sequencer.
interface boot_load_seq_if
  import boot_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W
);
  logic [DATA_W-1:0] LOAD_DATA;
  logic              LOAD_VALID;
  logic              LOAD_LAST;
  logic              LOAD_READY;
  logic              RAM_WE;
  logic [ADDR_W-1:0] RAM_ADDRESS;
  logic [DATA_W-1:0] RAM_DATAIN;

  modport master (
    output LOAD_DATA, LOAD_VALID, LOAD_LAST,
    input  LOAD_READY, RAM_WE, RAM_ADDRESS, RAM_DATAIN
  );

  modport slave (
    input  LOAD_DATA, LOAD_VALID, LOAD_LAST,
    output LOAD_READY, RAM_WE, RAM_ADDRESS, RAM_DATAIN
  );
endinterface

// File: rtl/boot_load_seq_cycle_cnt.sv
// Loadable down-counter; expire_o is high while the count sits at zero.
module boot_cycle_cnt #(
  parameter int W = 4
) (
  input  logic         clk_i,
  input  logic         rst_n_i,
  input  logic         load_i,
  input  logic         en_i,
  input  logic [W-1:0] val_i,
  output logic         expire_o
);
  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)
      cnt_d = val_i;
    else if (en_i && (cnt_q != '0))
      cnt_d = cnt_q - W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expire_o = (cnt_q == '0);
endmodule

// File: rtl/boot_load_seq.sv
// Boot sequencer: streams an image into RAM, holds the core in reset, then supervises it.
// Optional RUN watchdog enabled by defining BOOT_WATCHDOG_EN.
module boot_load_seq
  import boot_pkg::*;
#(
  parameter int DATA_W       = DEF_DATA_W,
  parameter int ADDR_W       = DEF_ADDR_W,
  parameter int RESET_CYCLES = DEF_RESET_CYCLES,
  parameter int WD_LIMIT     = DEF_WD_LIMIT
) (
  input  logic              CLK,
  input  logic              RESET_N,
  input  logic              START,
  boot_load_seq_if.slave    bus,
  output logic              CORE_RESET_N,
  input  logic              CORE_HALT,
  output logic [ADDR_W:0]   WORDS_LOADED,
  output logic              BUSY,
  output logic              DONE,
  output logic              HALTED,
  output logic              ERROR,
  output logic              TIMEOUT
);
  localparam int CNT_W = cnt_width(RESET_CYCLES, WD_LIMIT);
  localparam logic [ADDR_W-1:0] ADDR_MAX = '1;

  boot_state_t       state_q;
  logic [ADDR_W-1:0] addr_q;
  logic [ADDR_W:0]   words_q;
  logic              ram_we_q;
  logic [ADDR_W-1:0] ram_addr_q;
  logic [DATA_W-1:0] ram_data_q;
  logic              core_rst_n_q;
  logic              halted_q, error_q, timeout_q;

  logic              hs, start_ok;
  logic              cnt_load, cnt_en, cnt_expire;
  logic [CNT_W-1:0]  cnt_val;

  assign hs       = (state_q == ST_LOAD) && bus.LOAD_VALID;
  assign start_ok = START && (state_q inside {ST_IDLE, ST_RUN, ST_FAULT});

  // The HOLD counter is reloaded with the watchdog limit as the core leaves reset.
  assign cnt_load = (hs && bus.LOAD_LAST) || ((state_q == ST_HOLD) && cnt_expire);
  assign cnt_val  = (state_q == ST_HOLD) ? CNT_W'(WD_LIMIT - 1) : CNT_W'(RESET_CYCLES);
  assign cnt_en   = (state_q == ST_HOLD) || (state_q == ST_RUN);

  boot_cycle_cnt #(.W(CNT_W)) u_cnt (
    .clk_i    (CLK),
    .rst_n_i  (RESET_N),
    .load_i   (cnt_load),
    .en_i     (cnt_en),
    .val_i    (cnt_val),
    .expire_o (cnt_expire)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q      <= ST_IDLE;
      addr_q       <= '0;
      words_q      <= '0;
      ram_we_q     <= 1'b0;
      ram_addr_q   <= '0;
      ram_data_q   <= '0;
      core_rst_n_q <= 1'b0;
      halted_q     <= 1'b0;
      error_q      <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      ram_we_q <= 1'b0;
      if (start_ok) begin
        // A halt arriving together with START is still recorded.
        state_q      <= ST_LOAD;
        addr_q       <= '0;
        words_q      <= '0;
        core_rst_n_q <= 1'b0;
        halted_q     <= (state_q == ST_RUN) && CORE_HALT;
        error_q      <= 1'b0;
        timeout_q    <= 1'b0;
      end else begin
        case (state_q)
          ST_LOAD: begin
            if (hs) begin
              ram_we_q   <= 1'b1;
              ram_addr_q <= addr_q;
              ram_data_q <= bus.LOAD_DATA;
              addr_q     <= addr_q + ADDR_W'(1);
              words_q    <= words_q + (ADDR_W+1)'(1);
              if (bus.LOAD_LAST) begin
                state_q <= ST_HOLD;
              end else if (addr_q == ADDR_MAX) begin
                state_q <= ST_FAULT;
                error_q <= 1'b1;
              end
            end
          end
          ST_HOLD: begin
            if (cnt_expire) begin
              state_q      <= ST_RUN;
              core_rst_n_q <= 1'b1;
            end
          end
          ST_RUN: begin
            if (CORE_HALT) begin
              state_q      <= ST_IDLE;
              core_rst_n_q <= 1'b0;
              halted_q     <= 1'b1;
            end
`ifdef BOOT_WATCHDOG_EN
            else if (cnt_expire) begin
              state_q      <= ST_FAULT;
              core_rst_n_q <= 1'b0;
              timeout_q    <= 1'b1;
              error_q      <= 1'b1;
            end
`endif
          end
          ST_IDLE, ST_FAULT: ;
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign bus.LOAD_READY  = (state_q == ST_LOAD);
  assign bus.RAM_WE      = ram_we_q;
  assign bus.RAM_ADDRESS = ram_addr_q;
  assign bus.RAM_DATAIN  = ram_data_q;
  assign CORE_RESET_N    = core_rst_n_q;
  assign WORDS_LOADED    = words_q;
  assign BUSY            = (state_q == ST_LOAD) || (state_q == ST_HOLD);
  assign DONE            = (state_q == ST_RUN);
  assign HALTED          = halted_q;
  assign ERROR           = error_q;
  assign TIMEOUT         = timeout_q;
endmodule

// File: tb/tb_boot_load_seq.sv
// Directed bench for boot_load_seq (ADDR_W=3, RESET_CYCLES=2, WD_LIMIT=16).
module tb_boot_load_seq;
  localparam int DW  = 32;
  localparam int AW  = 3;
  localparam int RC  = 2;
  localparam int WDL = 16;

  logic          CLK = 1'b0;
  logic          RESET_N, START, CORE_HALT;
  logic          CORE_RESET_N, BUSY, DONE, HALTED, ERROR, TIMEOUT;
  logic [AW:0]   WORDS_LOADED;
  int            checks = 0;
  int            failures = 0;

  boot_load_seq_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  boot_load_seq #(.DATA_W(DW), .ADDR_W(AW), .RESET_CYCLES(RC), .WD_LIMIT(WDL)) dut (
    .CLK          (CLK),
    .RESET_N      (RESET_N),
    .START        (START),
    .bus          (bus),
    .CORE_RESET_N (CORE_RESET_N),
    .CORE_HALT    (CORE_HALT),
    .WORDS_LOADED (WORDS_LOADED),
    .BUSY         (BUSY),
    .DONE         (DONE),
    .HALTED       (HALTED),
    .ERROR        (ERROR),
    .TIMEOUT      (TIMEOUT)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  function automatic logic [46:0] all_outs();
    return {CORE_RESET_N, bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN, WORDS_LOADED,
            BUSY, DONE, HALTED, ERROR, TIMEOUT, bus.LOAD_READY};
  endfunction

  task automatic test_reset();
    RESET_N = 1'b0; START = 1'b1; bus.LOAD_VALID = 1'b1;
    step(); step();
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL reset_outputs got=%h exp=0", all_outs());
    end
    START = 1'b0; bus.LOAD_VALID = 1'b0;
    RESET_N = 1'b1;
    step();
    checks++;
    if ({bus.LOAD_READY, BUSY, CORE_RESET_N} !== 3'b000) begin
      failures++; $display("FAIL idle_after_reset got=%b exp=000", {bus.LOAD_READY, BUSY, CORE_RESET_N});
    end
  endtask

  task automatic test_back_to_back();
    logic [AW+DW:0] exp;
    START = 1'b1; step(); START = 1'b0;
    checks++;
    if ({bus.LOAD_READY, BUSY, WORDS_LOADED} !== {2'b11, 4'd0}) begin
      failures++; $display("FAIL b2b_enter_load got=%b exp=110000", {bus.LOAD_READY, BUSY, WORDS_LOADED});
    end
    for (int i = 0; i < 4; i++) begin
      bus.LOAD_VALID = 1'b1; bus.LOAD_DATA = 32'hA000_0000 + 32'(i); bus.LOAD_LAST = (i == 3);
      step();
      exp = {1'b1, AW'(i), 32'hA000_0000 + 32'(i)};
      checks++;
      if ({bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN} !== exp) begin
        failures++; $display("FAIL b2b_write%0d got=%h exp=%h", i, {bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN}, exp);
      end
    end
    bus.LOAD_VALID = 1'b0; bus.LOAD_LAST = 1'b0;
    checks++;
    if ({WORDS_LOADED, bus.LOAD_READY, CORE_RESET_N, BUSY} !== {4'd4, 3'b001}) begin
      failures++; $display("FAIL b2b_hold_entry got=%b exp=0100001", {WORDS_LOADED, bus.LOAD_READY, CORE_RESET_N, BUSY});
    end
    for (int k = 1; k <= 3; k++) begin
      step();
      checks++;
      if ({CORE_RESET_N, DONE, bus.RAM_WE} !== {(k == 3), (k == 3), 1'b0}) begin
        failures++; $display("FAIL b2b_release_k%0d got=%b exp=%b", k, {CORE_RESET_N, DONE, bus.RAM_WE}, {(k == 3), (k == 3), 1'b0});
      end
    end
  endtask

  task automatic test_toggle_valid();
    logic [AW+DW:0] exp;
    START = 1'b1; step(); START = 1'b0;
    checks++;
    if ({CORE_RESET_N, bus.LOAD_READY, WORDS_LOADED} !== {2'b01, 4'd0}) begin
      failures++; $display("FAIL tog_restart got=%b exp=010000", {CORE_RESET_N, bus.LOAD_READY, WORDS_LOADED});
    end
    for (int i = 0; i < 8; i++) begin
      bus.LOAD_VALID = (i % 2 == 0); bus.LOAD_DATA = 32'hB000_0000 + 32'(i / 2); bus.LOAD_LAST = (i == 6);
      step();
      exp = (i % 2 == 0) ? {1'b1, AW'(i / 2), 32'hB000_0000 + 32'(i / 2)} : {1'b0, bus.RAM_ADDRESS, bus.RAM_DATAIN};
      checks++;
      if ({bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN} !== exp) begin
        failures++; $display("FAIL tog_cycle%0d got=%h exp=%h", i, {bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN}, exp);
      end
      if (i < 6 && i % 2 == 1) begin
        checks++;
        if (bus.LOAD_READY !== 1'b1) begin
          failures++; $display("FAIL tog_ready_idle%0d got=%b exp=1", i, bus.LOAD_READY);
        end
      end
    end
    bus.LOAD_VALID = 1'b0; bus.LOAD_LAST = 1'b0;
    checks++;
    if ({WORDS_LOADED, CORE_RESET_N} !== {4'd4, 1'b0}) begin
      failures++; $display("FAIL tog_words got=%b exp=01000", {WORDS_LOADED, CORE_RESET_N});
    end
    step(); step();
    checks++;
    if ({DONE, CORE_RESET_N} !== 2'b11) begin
      failures++; $display("FAIL tog_run got=%b exp=11", {DONE, CORE_RESET_N});
    end
  endtask

  task automatic test_halt();
    CORE_HALT = 1'b1; step(); CORE_HALT = 1'b0;
    checks++;
    if ({DONE, BUSY, CORE_RESET_N, HALTED} !== 4'b0001) begin
      failures++; $display("FAIL halt_idle got=%b exp=0001", {DONE, BUSY, CORE_RESET_N, HALTED});
    end
    step();
    checks++;
    if ({HALTED, CORE_RESET_N} !== 2'b10) begin
      failures++; $display("FAIL halt_sticky got=%b exp=10", {HALTED, CORE_RESET_N});
    end
    START = 1'b1; step(); START = 1'b0;
    checks++;
    if ({HALTED, BUSY, WORDS_LOADED} !== {2'b01, 4'd0}) begin
      failures++; $display("FAIL halt_restart got=%b exp=010000", {HALTED, BUSY, WORDS_LOADED});
    end
    bus.LOAD_VALID = 1'b1; bus.LOAD_DATA = 32'hC0C0_0000; bus.LOAD_LAST = 1'b1;
    step();
    bus.LOAD_VALID = 1'b0; bus.LOAD_LAST = 1'b0;
    checks++;
    if ({bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN} !== {1'b1, 3'd0, 32'hC0C0_0000}) begin
      failures++; $display("FAIL halt_addr0 got=%h exp=%h", {bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN}, {1'b1, 3'd0, 32'hC0C0_0000});
    end
    step(); step(); step();
    checks++;
    if (DONE !== 1'b1) begin
      failures++; $display("FAIL halt_rerun got=%b exp=1", DONE);
    end
  endtask

  task automatic test_start_halt_together();
    START = 1'b1; CORE_HALT = 1'b1; step(); START = 1'b0; CORE_HALT = 1'b0;
    checks++;
    if ({BUSY, HALTED, CORE_RESET_N, DONE} !== 4'b1100) begin
      failures++; $display("FAIL start_halt got=%b exp=1100", {BUSY, HALTED, CORE_RESET_N, DONE});
    end
  endtask

  task automatic test_reset_midload();
    for (int i = 0; i < 2; i++) begin
      bus.LOAD_VALID = 1'b1; bus.LOAD_DATA = 32'hD000_0000 + 32'(i); bus.LOAD_LAST = 1'b0;
      step();
    end
    checks++;
    if ({bus.RAM_WE, bus.RAM_ADDRESS, WORDS_LOADED} !== {1'b1, 3'd1, 4'd2}) begin
      failures++; $display("FAIL mid_second_word got=%b exp=10010010", {bus.RAM_WE, bus.RAM_ADDRESS, WORDS_LOADED});
    end
    bus.LOAD_DATA = 32'hD000_0002; RESET_N = 1'b0;
    step();
    checks++;
    if (all_outs() !== '0) begin
      failures++; $display("FAIL mid_reset_outputs got=%h exp=0", all_outs());
    end
    RESET_N = 1'b1; bus.LOAD_VALID = 1'b0;
    step();
    START = 1'b1; step(); START = 1'b0;
    bus.LOAD_VALID = 1'b1; bus.LOAD_DATA = 32'hE000_0000; bus.LOAD_LAST = 1'b1;
    step();
    bus.LOAD_VALID = 1'b0; bus.LOAD_LAST = 1'b0;
    checks++;
    if ({bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN, WORDS_LOADED} !== {1'b1, 3'd0, 32'hE000_0000, 4'd1}) begin
      failures++; $display("FAIL mid_restart got=%h exp=%h", {bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN, WORDS_LOADED}, {1'b1, 3'd0, 32'hE000_0000, 4'd1});
    end
  endtask

  task automatic test_overflow();
    RESET_N = 1'b0; step(); RESET_N = 1'b1;
    START = 1'b1; step(); START = 1'b0;
    for (int i = 0; i < 8; i++) begin
      bus.LOAD_VALID = 1'b1; bus.LOAD_DATA = 32'hF000_0000 + 32'(i); bus.LOAD_LAST = 1'b0;
      step();
      checks++;
      if ({bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN} !== {1'b1, AW'(i), 32'hF000_0000 + 32'(i)}) begin
        failures++; $display("FAIL ovf_write%0d got=%h exp=%h", i, {bus.RAM_WE, bus.RAM_ADDRESS, bus.RAM_DATAIN}, {1'b1, AW'(i), 32'hF000_0000 + 32'(i)});
      end
    end
    checks++;
    if ({ERROR, BUSY, bus.LOAD_READY, CORE_RESET_N, WORDS_LOADED} !== {4'b1000, 4'd8}) begin
      failures++; $display("FAIL ovf_fault got=%b exp=10001000", {ERROR, BUSY, bus.LOAD_READY, CORE_RESET_N, WORDS_LOADED});
    end
    for (int k = 0; k < 3; k++) begin
      step();
      checks++;
      if ({bus.RAM_WE, CORE_RESET_N, ERROR} !== 3'b001) begin
        failures++; $display("FAIL ovf_stay%0d got=%b exp=001", k, {bus.RAM_WE, CORE_RESET_N, ERROR});
      end
    end
    bus.LOAD_VALID = 1'b0;
    START = 1'b1; step(); START = 1'b0;
    checks++;
    if ({ERROR, BUSY, WORDS_LOADED} !== {2'b01, 4'd0}) begin
      failures++; $display("FAIL ovf_restart got=%b exp=010000", {ERROR, BUSY, WORDS_LOADED});
    end
  endtask

  task automatic test_run_length();
    int done_cnt = 0;
    bus.LOAD_VALID = 1'b1; bus.LOAD_DATA = 32'h0000_0013; bus.LOAD_LAST = 1'b1;
    step();
    bus.LOAD_VALID = 1'b0; bus.LOAD_LAST = 1'b0;
    step(); step(); step();
    checks++;
    if ({DONE, CORE_RESET_N} !== 2'b11) begin
      failures++; $display("FAIL run_entry got=%b exp=11", {DONE, CORE_RESET_N});
    end
`ifdef BOOT_WATCHDOG_EN
    for (int k = 1; k < WDL; k++) begin
      step();
      if (DONE === 1'b1 && TIMEOUT === 1'b0) done_cnt++;
    end
    checks++;
    if (done_cnt != WDL - 1) begin
      failures++; $display("FAIL wd_early got=%0d exp=%0d", done_cnt, WDL - 1);
    end
    step();
    checks++;
    if ({TIMEOUT, ERROR, DONE, CORE_RESET_N} !== 4'b1100) begin
      failures++; $display("FAIL wd_timeout got=%b exp=1100", {TIMEOUT, ERROR, DONE, CORE_RESET_N});
    end
`else
    for (int k = 0; k < 100; k++) begin
      step();
      if (DONE === 1'b1 && CORE_RESET_N === 1'b1 && TIMEOUT === 1'b0 && ERROR === 1'b0) done_cnt++;
    end
    checks++;
    if (done_cnt != 100) begin
      failures++; $display("FAIL run_hold got=%0d exp=100", done_cnt);
    end
`endif
  endtask

  initial begin
    RESET_N = 1'b0; START = 1'b0; CORE_HALT = 1'b0;
    bus.LOAD_VALID = 1'b0; bus.LOAD_LAST = 1'b0; bus.LOAD_DATA = '0;
    test_reset();
    test_back_to_back();
    test_toggle_valid();
    test_halt();
    test_start_halt_together();
    test_reset_midload();
    test_overflow();
    test_run_length();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/boot_load_seq.md
# boot_load_seq

Synthesizable boot sequencer placed between the testbench/host loader and the single-cycle RISC-V `TOP`. It replaces ad-hoc `$readmemh` preloading and fixed two-cycle reset tasks. The block streams a program image into instruction/data RAM over a valid/ready port and holds the core in reset for a parametrised number of cycles. It then releases the core and supervises it until a halt (or, optionally, a watchdog timeout).

## Interface
Parameters:
- `DATA_W`, 32, RAM word width.
- `ADDR_W`, 10, RAM word-address width; image depth is 2**ADDR_W words.
- `RESET_CYCLES`, 2, core-reset hold cycles after load completes (≥1).
- `WD_LIMIT`, 1024, watchdog limit in RUN cycles (used only with `BOOT_WATCHDOG_EN`).

Ports (one clock `CLK`; reset `RESET_N` is synchronous, active-low):
- `CLK` in 1 — system clock, rising edge.
- `RESET_N` in 1 — synchronous active-low reset.
- `START` in 1 — begin (re)load; sampled in IDLE, RUN, FAULT.
- `LOAD_DATA` in DATA_W — image word.
- `LOAD_VALID` in 1 — LOAD_DATA valid.
- `LOAD_LAST` in 1 — qualifies the final image word.
- `LOAD_READY` out 1 — block accepts a word this cycle.
- `RAM_WE` out 1 — registered RAM write strobe.
- `RAM_ADDRESS` out ADDR_W — registered write address.
- `RAM_DATAIN` out DATA_W — registered write data.
- `CORE_RESET_N` out 1 — reset to `TOP`, active-low.
- `CORE_HALT` in 1 — core signals end of program.
- `WORDS_LOADED` out ADDR_W+1 — words written in the last load.
- `BUSY` out 1 — state is LOAD or HOLD.
- `DONE` out 1 — state is RUN.
- `HALTED` out 1 — sticky; set by CORE_HALT in RUN.
- `ERROR` out 1 — sticky; set on image overflow or timeout.
- `TIMEOUT` out 1 — sticky watchdog flag.

## Operation
- States: IDLE, LOAD, HOLD, RUN, FAULT.
- **IDLE**
  - `CORE_RESET_N`=0, `LOAD_READY`=0.
  - `START`=1 → LOAD: clear address, `WORDS_LOADED`, `HALTED`, `ERROR`, `TIMEOUT`.
- **LOAD**
  - `LOAD_READY`=1, `CORE_RESET_N`=0.
  - Handshake = `LOAD_VALID & LOAD_READY`.
  - Each handshake writes `LOAD_DATA` to the current address; address and `WORDS_LOADED` increment.
  - `LOAD_LAST` on a handshake → HOLD.
  - Handshake at address 2**ADDR_W−1 without `LOAD_LAST` → word is written, then FAULT with `ERROR`=1. No wrap-around.
  - `START` is ignored in LOAD.
- **HOLD**
  - `CORE_RESET_N`=0, `LOAD_READY`=0.
  - Counter runs RESET_CYCLES cycles, then → RUN.
- **RUN**
  - `CORE_RESET_N`=1, `DONE`=1.
  - `CORE_HALT`=1 → IDLE, `HALTED`=1.
  - `START`=1 → LOAD; `CORE_RESET_N` drops in the same transition.
  - `START` and `CORE_HALT` together → `START` wins and `HALTED` is set.
- **FAULT**
  - `CORE_RESET_N`=0, `ERROR`=1.
  - `START` → LOAD with flags cleared.
- `RESET_N`=0 in any state, including mid-load → IDLE next edge.
  - All outputs 0: `CORE_RESET_N`=0, `RAM_WE`=0, `RAM_ADDRESS`=0, `RAM_DATAIN`=0, `WORDS_LOADED`=0, all flags 0.
  - RAM contents are untouched.

## Timing
- Handshake at edge n → `RAM_WE`=1 with address/data during cycle n+1; single-cycle pulse per word.
- Back-to-back handshakes give one write per cycle; no bubbles.
- `LOAD_LAST` accepted at edge n → HOLD from n+1; `CORE_RESET_N` rises at edge n+1+RESET_CYCLES.
- The last RAM write (cycle n+1) always completes while the core is still in reset.
- `LOAD_READY` is a function of state only; it does not depend on `LOAD_VALID`.
- Flags update one edge after their cause.

## Configuration
- Macro `BOOT_WATCHDOG_EN`.
- **Defined:** a RUN-cycle counter clears on entry to RUN. If it reaches WD_LIMIT without `CORE_HALT`, the block goes to FAULT with `TIMEOUT`=1 and `ERROR`=1. `CORE_HALT` on the limit cycle wins.
- **Undefined:** no counter; `TIMEOUT` is tied to 0 and RUN lasts indefinitely. The port list is identical in both builds.

## Structure
- Package `boot_pkg`:
  - State enum `boot_state_t`.
  - Default constants for DATA_W, ADDR_W, RESET_CYCLES, WD_LIMIT.
- Sub-module `boot_cycle_cnt`: a parametrised down-counter with load/expire, used by HOLD and by the watchdog.

## Test plan
- Reset, `START`, stream 4 words with `LOAD_LAST` on the 4th, back-to-back → `RAM_WE` pulses at addresses 0–3 on consecutive cycles; `WORDS_LOADED`=4; `CORE_RESET_N` rises exactly 3 cycles after `LOAD_LAST` is accepted (RESET_CYCLES=2).
- `LOAD_VALID` toggling every other cycle → 4 writes, no duplicates, addresses 0–3.
- ADDR_W=3, 8 words with no `LOAD_LAST` → 8 writes, FAULT, `ERROR`=1, `CORE_RESET_N` stays 0.
- RUN then `CORE_HALT`=1 → IDLE and `HALTED`=1; a second `START` clears `HALTED` and restarts at address 0.
- `RESET_N`=0 after 2 of 5 words → all outputs 0 on the next edge; the next load restarts at address 0.
- With `BOOT_WATCHDOG_EN`, WD_LIMIT=16, no halt → `TIMEOUT`=`ERROR`=1 at RUN cycle 16; without the macro, `DONE` holds for 100 cycles.
